// File: rtl/execute_cycle.sv
// execute_cycle: EX stage of the 18-bit pipelined processor.
//   - Operand forwarding (ForwardA_E/ForwardB_E), ALU, beq resolution.
//   - MUL is an iterative shift-add FSM. StallE freezes IF/ID/EX while it runs.
//   - Ends in the EX/MEM register that feeds memory_cycle.
// Ports:
//   clk, rst (async, active low)
//   *E     : decoded EX-stage controls and operands, forwarding selects, ResultW
//   PCSrcE, PCTargetE : combinational branch decision and target
//   StallE : MUL in progress
//   *M     : registered EX/MEM outputs
module execute_cycle #(
  parameter int DATA_W = 18,
  parameter int PC_W   = 9,
  parameter int REG_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic              ALUSrcE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [REG_W-1:0]  RD_E,
  input  logic [PC_W-1:0]   PCE,
  input  logic [PC_W-1:0]   PCPlus4E,
  input  logic [1:0]        ForwardA_E,
  input  logic [1:0]        ForwardB_E,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [PC_W-1:0]   PCTargetE,
  output logic              StallE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_W-1:0]  RD_M,
  output logic [PC_W-1:0]   PCPlus4M,
  output logic [DATA_W-1:0] ALU_ResultM,
  output logic [DATA_W-1:0] WriteDataM
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mul_state_t;

  mul_state_t        state, state_n;
  logic [DATA_W-1:0] src_a, fwd_b, src_b, diff, alu_result;
  logic [DATA_W-1:0] mcand, mplr, acc;
  logic [CNT_W-1:0]  cnt;
  logic              is_mul, stall;

  // Forwarding muxes; select 11 falls back to the register-file operand.
  always_comb begin
    case (ForwardA_E)
      2'b01:   src_a = ResultW;
      2'b10:   src_a = ALU_ResultM;
      default: src_a = RD1_E;
    endcase
    case (ForwardB_E)
      2'b01:   fwd_b = ResultW;
      2'b10:   fwd_b = ALU_ResultM;
      default: fwd_b = RD2_E;
    endcase
  end

  assign src_b  = ALUSrcE ? Imm_Ext_E : fwd_b;
  assign diff   = src_a - src_b;
  assign is_mul = (ALUControlE == 3'b111);

  assign PCSrcE    = BranchE & (diff == '0);
  assign PCTargetE = PCE + Imm_Ext_E[PC_W-1:0];

  // MUL controller. The stall is masked by reset so the front end is
  // released immediately when a multiply is aborted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  always_comb begin
    state_n = state;
    stall   = 1'b0;
    case (state)
      IDLE: if (is_mul) begin
        stall   = 1'b1;
        state_n = BUSY;
      end
      BUSY: begin
        stall = 1'b1;
        if (cnt == CNT_LAST) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign StallE = stall & rst;

  // Shift-add datapath. Operands are captured on entry so forwarding changes
  // while the front end is frozen cannot disturb the product.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (is_mul) begin
          mcand <= src_a;
          mplr  <= src_b;
          acc   <= '0;
          cnt   <= '0;
        end
        BUSY: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_result = '0;
    case (ALUControlE)
      3'b000: alu_result = src_a + src_b;
      3'b001: alu_result = diff;
      3'b010: alu_result = src_a & src_b;
      3'b011: alu_result = src_a | src_b;
      3'b100: alu_result = src_a ^ src_b;
      3'b101: alu_result = {{(DATA_W-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
      3'b110: alu_result = src_a << src_b[3:0];
      3'b111: alu_result = (state == DONE) ? acc : '0;
      default: alu_result = '0;
    endcase
  end

  // EX/MEM register: loads every edge, a bubble while stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
    end else if (stall) begin
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 1'b0;
      RD_M        <= '0;
      PCPlus4M    <= '0;
      ALU_ResultM <= '0;
      WriteDataM  <= '0;
    end else begin
      RegWriteM   <= RegWriteE;
      MemWriteM   <= MemWriteE;
      ResultSrcM  <= ResultSrcE;
      RD_M        <= RD_E;
      PCPlus4M    <= PCPlus4E;
      ALU_ResultM <= alu_result;
      WriteDataM  <= fwd_b;
    end
  end

endmodule
